reg16_bank_arbiter: RTL and testbench
=====================================

Name: reg16_bank_arbiter

Overview:
- Shares a bank of N_REG 16-bit structural registers (reg_16 instances, no load enable) between two requesters (port 0, port 1).
- Round-robin arbitration, a req/gnt/rvalid handshake, and generation of every register's D input.
- Because the bank has no enable, this block recirculates each register's Q to its D except in the single cycle that register is written.
- Sits between the delta-sigma control logic (coefficient loader, host interface) and the register bank.

Parameters:
- N_REG, 4, number of 16-bit registers in the bank.
- ADDR_W, 2, address width; must equal clog2(N_REG).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 access request; held until gnt0.
- we0  input  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  input  ADDR_W  port 0 register index; stable while req0 is high.
- wdata0  input  16  port 0 write data; stable while req0 is high.
- gnt0  output  1  one-cycle pulse: port 0 access performed this cycle.
- rvalid0  output  1  one-cycle pulse: rdata valid for port 0's read.
- req1, we1, addr1, wdata1, gnt1, rvalid1: identical set for port 1.
- rdata  output  16  shared read data, qualified by rvalid0/rvalid1.
- bank_q  input  16*N_REG  flattened register Q outputs; reg i = bits [16i+15:16i].
- bank_d  output  16*N_REG  flattened register D inputs, same packing.
- bank_set  output  16*N_REG  per-bit set to the bank; constant 0.
- bank_clr  output  16*N_REG  per-bit clear to the bank; all ones while reset is high, else 0.

Behaviour:
- Reset values:
  - gnt0/gnt1/rvalid0/rvalid1 = 0, rdata = 0.
  - FSM = IDLE, priority pointer = 0 (port 0 favoured).
  - bank_d = bank_q (recirculate); bank_clr = all ones for every cycle reset is high.
- Default, every cycle: bank_d[i] = bank_q[i] for all i.
- FSM IDLE:
  - No request: stay in IDLE.
  - Any request: register winner, we, addr and wdata into an access latch; go to ACCESS.
- Arbitration when both requests are high: the port indicated by the pointer wins.
- FSM ACCESS (one cycle):
  - Pulse gnt of the winner.
  - Write: bank_d[addr] = latched wdata, so the bank captures it at the end of this cycle.
  - Read: rdata register loads bank_q[addr].
  - Pointer = other port.
  - Next state is RESP for a read, IDLE for a write.
- FSM RESP (one cycle): rvalid of the winner = 1 with rdata held; next state IDLE.
- Latency, request seen at edge t:
  - gnt at t+1.
  - Written value visible on bank_q from t+2.
  - Read rvalid at t+2.
  - Back-to-back: next grant no earlier than t+3 after a write, t+4 after a read.
- Requester rules:
  - A requester deasserts req in the cycle after gnt, or keeps it high for a new access.
  - Dropping req before gnt is illegal; the latched access still completes.
- The losing requester is never starved: it is granted on the next arbitration.
- Address out of range (addr >= N_REG): write discarded (all registers recirculate); read returns 0. gnt and rvalid still pulse.
- Read-after-write to the same address from the other port returns the new value, because ACCESS is sequential.
- reset asserted in any state: next cycle is IDLE with outputs at reset values. An in-flight write is dropped unless its ACCESS edge coincides with reset deassertion (it does not; reset wins). The bank is cleared by bank_clr.
- rdata holds its last value between reads.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), REG_W=16, and a macro for slicing reg i from flattened buses.
- One sub-module: rr_arb2, a two-way round-robin arbiter.
  - Inputs: req[1:0], ptr, advance.
  - Outputs: one-hot grant[1:0] and updated ptr.
- The D-mux generate loop stays in the top module.

Test Plan:
- Reset then idle, bank preloaded via bank_q = 0x1234 (reg0) → bank_d reg0 = 0x1234; bank_clr all ones while reset is high, 0 after; no gnt.
- req0 write addr=2, wdata=0xBEEF → gnt0 one cycle later; bank_d reg2 = 0xBEEF for exactly that cycle; other regs recirculate.
- req1 read addr=2 after that write → gnt1 at t+1; rvalid1 at t+2 with rdata = 0xBEEF; rvalid0 stays 0.
- req0 and req1 both held high continuously, writes to addr0/addr1 → grants alternate 0,1,0,1 starting with port 0 after reset.
- reset pulsed in ACCESS of a write 0xAAAA to addr1 → no gnt after reset; FSM IDLE; reg1 not loaded with 0xAAAA.
- Read addr=3 with N_REG=3 → gnt and rvalid pulse, rdata = 0x0000; no register changes.

Source files
------------

// File: rtl/reg16_bank_arbiter_pkg.sv
// Shared types for the 16-bit register bank arbiter: FSM encoding, register
// width and a slice helper for the flattened bank buses.
package reg16_bank_arbiter_pkg;
    localparam int REG_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;
endpackage

`define REG16_SLICE(bus, i) bus[(i)*reg16_bank_arbiter_pkg::REG_W +: reg16_bank_arbiter_pkg::REG_W]

// File: rtl/reg16_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the favoured port on a tie
// and moves past the winner whenever a grant is taken.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);
    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
        ptr_o = ptr_i;
        if (advance_i && (grant_o != 2'b00)) begin
            ptr_o = grant_o[0];
        end
    end
endmodule

// File: rtl/reg16_bank_arbiter.sv
// Arbitrates two requesters onto an enable-less register bank: recirculates
// every Q to its D except for the one register written in the ACCESS cycle.
module reg16_bank_arbiter
    import reg16_bank_arbiter_pkg::*;
#(
    parameter int N_REG  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       addr0,
    input  logic [REG_W-1:0]        wdata0,
    output logic                    gnt0,
    output logic                    rvalid0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       addr1,
    input  logic [REG_W-1:0]        wdata1,
    output logic                    gnt1,
    output logic                    rvalid1,
    output logic [REG_W-1:0]        rdata,
    input  logic [REG_W*N_REG-1:0]  bank_q,
    output logic [REG_W*N_REG-1:0]  bank_d,
    output logic [REG_W*N_REG-1:0]  bank_set,
    output logic [REG_W*N_REG-1:0]  bank_clr,
    output state_t                  dbg_state_o
);
    // Handshake: a requester holds req (with we/addr/wdata stable) until its
    // one-cycle gnt; a read is answered by a one-cycle rvalid the cycle after.
    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [REG_W-1:0]    wdata_q, wdata_d;
    logic [REG_W-1:0]    rdata_q, rdata_d;
    logic [1:0]          grant;
    logic                ptr_next;
    logic                addr_ok;
    logic                wr_en;

    rr_arb2 u_arb (
        .req_i     ({req1, req0}),
        .ptr_i     (ptr_q),
        .advance_i (state_q == ST_IDLE),
        .grant_o   (grant),
        .ptr_o     (ptr_next)
    );

    assign addr_ok = int'(addr_q) < N_REG;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    ptr_d   = ptr_next;
                    win_d   = grant[1];
                    we_d    = grant[1] ? we1 : we0;
                    addr_d  = grant[1] ? addr1 : addr0;
                    wdata_d = grant[1] ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    rdata_d = '0;
                    for (int i = 0; i < N_REG; i++) begin
                        if (addr_ok && (int'(addr_q) == i)) begin
                            rdata_d = `REG16_SLICE(bank_q, i);
                        end
                    end
                end
                state_d = we_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset wins over an access caught mid-flight: no grant, no write.
    assign wr_en   = (state_q == ST_ACCESS) && we_q && addr_ok && !reset;
    assign gnt0    = (state_q == ST_ACCESS) && !win_q && !reset;
    assign gnt1    = (state_q == ST_ACCESS) &&  win_q && !reset;
    assign rvalid0 = (state_q == ST_RESP) && !win_q && !reset;
    assign rvalid1 = (state_q == ST_RESP) &&  win_q && !reset;
    assign rdata   = rdata_q;

    for (genvar i = 0; i < N_REG; i++) begin : g_dmux
        assign `REG16_SLICE(bank_d, i) = (wr_en && (addr_q == ADDR_W'(i))) ?
                                         wdata_q : `REG16_SLICE(bank_q, i);
    end

    assign bank_set    = '0;
    assign bank_clr    = {(REG_W*N_REG){reset}};
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_reg16_bank_arbiter.sv
// Bench for reg16_bank_arbiter with a three-register bank so index 3 is out
// of range; models the enable-less bank behind bank_d/bank_q.
module tb_reg16_bank_arbiter;
  import reg16_bank_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int BW = 16 * NR;

  logic          CLK = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [1:0]    addr0, addr1;
  logic [15:0]   wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0]   rdata;
  logic [BW-1:0] bank_q, bank_d, bank_set, bank_clr;
  state_t        dbg_state;

  logic          load_req;
  logic [BW-1:0] load_val;

  int total = 0;
  int bad = 0;

  logic [0:0] exp_q[$];
  logic [0:0] act_q[$];

  reg16_bank_arbiter #(.N_REG(NR), .ADDR_W(2)) dut (
    .CLK(CLK), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .bank_q(bank_q), .bank_d(bank_d), .bank_set(bank_set),
    .bank_clr(bank_clr), .dbg_state_o(dbg_state)
  );

  // clock / bank model
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (load_req) bank_q <= load_val;
    else          bank_q <= (bank_d & ~bank_clr) | bank_set;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] slice(input logic [BW-1:0] bus, input int i);
    return bus[i*16 +: 16];
  endfunction

  task automatic drive_port(input bit port, input bit req, input bit we,
                            input logic [1:0] addr, input logic [15:0] wdata);
    if (port) begin req1 = req; we1 = we; addr1 = addr; wdata1 = wdata; end
    else      begin req0 = req; we0 = we; addr0 = addr; wdata0 = wdata; end
  endtask

  task automatic do_access(input int idx, input bit port, input bit we,
                           input logic [1:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rdata);
    int waited = 0;
    drive_port(port, 1'b1, we, addr, wdata);
    tick();
    while (!(port ? gnt1 : gnt0) && waited < 8) begin
      tick();
      waited++;
    end
    check($sformatf("v%0d_gnt", idx), BW'(port ? gnt1 : gnt0), BW'(1));
    check($sformatf("v%0d_gnt_other", idx), BW'(port ? gnt0 : gnt1), BW'(0));
    if (we) begin
      for (int i = 0; i < NR; i++)
        check($sformatf("v%0d_bank_d%0d", idx, i), BW'(slice(bank_d, i)),
              BW'((int'(addr) == i) ? wdata : slice(bank_q, i)));
    end
    drive_port(port, 1'b0, we, addr, wdata);
    tick();
    if (we) begin
      check($sformatf("v%0d_idle", idx), BW'(dbg_state), BW'(ST_IDLE));
      if (int'(addr) < NR)
        check($sformatf("v%0d_bank_q", idx), BW'(slice(bank_q, int'(addr))), BW'(wdata));
    end else begin
      check($sformatf("v%0d_rvalid", idx), BW'(port ? rvalid1 : rvalid0), BW'(1));
      check($sformatf("v%0d_rvalid_other", idx), BW'(port ? rvalid0 : rvalid1), BW'(0));
      check($sformatf("v%0d_rdata", idx), BW'(rdata), BW'(exp_rdata));
      tick();
      check($sformatf("v%0d_rvalid_drop", idx), BW'({rvalid1, rvalid0}), BW'(0));
      check($sformatf("v%0d_rdata_hold", idx), BW'(rdata), BW'(exp_rdata));
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 2'd2, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b1, 2'd1, 16'h1111, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 2'd1, 16'h0000, 16'h1111};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 16'h0000, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 2'd3, 16'h0000, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 16'hDEAD, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h1234};
    vecs[8] = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'hBEEF};

    reset = 1'b1; load_req = 1'b0; load_val = '0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    bank_q = '0;

    // reset and preload
    tick(); tick();
    check("rst_state", BW'(dbg_state), BW'(ST_IDLE));
    check("rst_outs", BW'({gnt0, gnt1, rvalid0, rvalid1}), BW'(0));
    check("rst_rdata", BW'(rdata), BW'(0));
    check("rst_clr", bank_clr, {BW{1'b1}});
    check("rst_set", bank_set, '0);
    load_req = 1'b1;
    load_val = '0;
    load_val[15:0] = 16'h1234;
    tick();
    load_req = 1'b0;
    check("rst_recirc", BW'(slice(bank_d, 0)), BW'(16'h1234));
    reset = 1'b0;
    tick();
    check("post_rst_clr", bank_clr, '0);
    check("post_rst_bank0", BW'(slice(bank_q, 0)), BW'(16'h1234));
    check("post_rst_nognt", BW'({gnt0, gnt1}), BW'(0));

    // table-driven accesses
    for (int v = 0; v < 9; v++)
      do_access(v, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
    check("oor_write_no_change", bank_q,
          {16'hBEEF, 16'h1111, 16'h1234});

    // both ports requesting continuously: grants alternate from port 0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    act_q = {};
    drive_port(1'b0, 1'b1, 1'b1, 2'd0, 16'hA5A5);
    drive_port(1'b1, 1'b1, 1'b1, 2'd1, 16'h5A5A);
    for (int c = 0; c < 20 && act_q.size() < 4; c++) begin
      tick();
      if (gnt0 && gnt1) check("alt_onehot", BW'({gnt1, gnt0}), BW'(1));
      else if (gnt0) act_q.push_back(1'b0);
      else if (gnt1) act_q.push_back(1'b1);
    end
    req0 = 1'b0; req1 = 1'b0;
    check("alt_count", BW'(act_q.size()), BW'(4));
    while (exp_q.size() > 0 && act_q.size() > 0)
      check($sformatf("alt_grant%0d", 3 - act_q.size() + 1), BW'(act_q.pop_front()), BW'(exp_q.pop_front()));
    tick();
    check("alt_bank", bank_q, {16'h0000, 16'h5A5A, 16'hA5A5});

    // reset hits the ACCESS cycle of a write
    drive_port(1'b0, 1'b1, 1'b1, 2'd1, 16'hAAAA);
    tick();
    check("rstacc_in_access", BW'(dbg_state), BW'(ST_ACCESS));
    reset = 1'b1;
    #1;
    check("rstacc_no_gnt", BW'({gnt1, gnt0}), BW'(0));
    tick();
    check("rstacc_idle", BW'(dbg_state), BW'(ST_IDLE));
    req0 = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rstacc_quiet%0d", c), BW'({gnt1, gnt0, rvalid1, rvalid0}), BW'(0));
    end
    check("rstacc_reg1", BW'(slice(bank_q, 1)), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
